// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : axi_sram_slave
//  Purpose  : AXI4 slave (fixed 4-byte INCR bursts, one transaction at a time)
//             that bridges onto a single-port synchronous SRAM with a
//             one-cycle read latency.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             ar* / r*            - AXI read address and read data channels
//             aw* / w* / b*       - AXI write address, data, response channels
//             ram_*               - SRAM strobe, byte write enables, word
//                                   address, write data, read data
//  Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    // read address channel
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic              arvalid,
    output logic              arready,
    // read data channel
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // write address channel
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic              awvalid,
    output logic              awready,
    // write data channel
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // write response channel
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // SRAM port
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        RD_BEAT = 3'd3,
        WR_BEAT = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);
    localparam logic [3:0]        c_cnt_one  = 4'd1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_id;
    logic [3:0]          r_len;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic [31:0]         r_rdata;

    logic                w_last_beat;
    logic                w_aw_hs;
    logic                w_ar_hs;
    logic                w_unused;

    assign w_last_beat = (r_cnt == r_len);
    assign w_aw_hs     = awvalid && awready;
    assign w_ar_hs     = arvalid && arready;

    // Byte-offset bits and bits above the RAM window are deliberately ignored.
    assign w_unused    = ^{araddr, awaddr};

    assign rid       = r_id;
    assign bid       = r_id;
    assign rdata     = r_rdata;
    assign rresp     = 2'b00;
    assign rlast     = (r_state == RD_BEAT) && w_last_beat;
    assign bresp     = ((r_state == WR_RESP) && r_err) ? 2'b10 : 2'b00;
    assign ram_addr  = r_addr;

    // ------------------------------------------------------------------
    // Next state and channel/RAM strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        arready     = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        rvalid      = 1'b0;
        bvalid      = 1'b0;
        ram_en      = 1'b0;
        ram_we      = 4'b0000;
        ram_wdata   = 32'h0;
        case (r_state)
            IDLE: begin
                // Write wins a simultaneous request.
                awready = 1'b1;
                arready = !awvalid;
                if (awvalid) begin
                    w_state_nxt = WR_BEAT;
                end else if (arvalid) begin
                    w_state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                ram_en      = 1'b1;
                w_state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                w_state_nxt = RD_BEAT;
            end
            RD_BEAT: begin
                rvalid = 1'b1;
                if (rready) begin
                    w_state_nxt = w_last_beat ? IDLE : RD_REQ;
                end
            end
            WR_BEAT: begin
                wready = 1'b1;
                if (wvalid) begin
                    ram_en    = 1'b1;
                    ram_we    = wstrb;
                    ram_wdata = wdata;
                    // Beat count, not wlast, decides the end of the burst.
                    if (w_last_beat) begin
                        w_state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (bready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and transaction context registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_id    <= 4'h0;
            r_len   <= 4'h0;
            r_cnt   <= 4'h0;
            r_addr  <= '0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_id   <= awid;
                        r_addr <= awaddr[ADDR_W+1:2];
                        r_len  <= awlen;
                        r_cnt  <= 4'h0;
                        r_err  <= 1'b0;
                    end else if (w_ar_hs) begin
                        r_id   <= arid;
                        r_addr <= araddr[ADDR_W+1:2];
                        r_len  <= arlen;
                        r_cnt  <= 4'h0;
                        r_err  <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    r_rdata <= ram_rdata;
                end
                RD_BEAT: begin
                    if (rready && !w_last_beat) begin
                        r_addr <= r_addr + c_addr_one;
                        r_cnt  <= r_cnt + c_cnt_one;
                    end
                end
                WR_BEAT: begin
                    if (wvalid) begin
                        r_addr <= r_addr + c_addr_one;
                        r_cnt  <= r_cnt + c_cnt_one;
                        // Early, late or missing wlast is reported as SLVERR.
                        if (wlast != w_last_beat) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_axi_sram_slave
//  Purpose  : Self-checking bench for axi_sram_slave with a behavioural SRAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    arid, awid, rid, bid, wstrb, arlen, awlen;
    logic [31:0]   araddr, awaddr, rdata, wdata, ram_wdata, ram_rdata;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]    rresp, bresp;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;

    int checks   = 0;
    int failures = 0;

    // captured transaction results
    logic [AW-1:0] cap_addr [32];
    logic [3:0]    cap_we   [32];
    logic [31:0]   cap_rdata[16];
    logic          cap_rlast[16];
    int            cap_lat  [16];
    int            cap_n;
    logic [3:0]    cap_id;
    logic [1:0]    cap_bresp;

    logic [31:0]   mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural SRAM: one-cycle read latency, byte-lane writes.
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = {16'hC0DE, 16'(i)};
        ram_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture_strobe();
        if (ram_en && cap_n < 32) begin
            cap_addr[cap_n] = ram_addr;
            cap_we[cap_n]   = ram_we;
            cap_n++;
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] data0, input logic [3:0] strb, input int last_at);
        int n;
        cap_n = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 20) begin tick(); n++; end
        if (!awready) chk("aw_timeout", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = data0 + 32'(k); wstrb = strb; wlast = (k == last_at); wvalid = 1'b1;
            #1;
            capture_strobe();
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        if (!bvalid) chk("b_timeout", 32'(bvalid), 32'd1);
        cap_bresp = bresp; cap_id = bid;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int n;
        cap_n = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1; rready = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        if (!arready) chk("ar_timeout", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        for (int beat = 0; beat <= int'(len); beat++) begin
            n = 0;
            while (!rvalid && n < 20) begin capture_strobe(); tick(); n++; end
            if (!rvalid) begin
                chk("r_timeout", 32'(rvalid), 32'd1);
                rready = 1'b0;
                return;
            end
            cap_lat[beat]   = n + 1;
            cap_rdata[beat] = rdata;
            cap_rlast[beat] = rlast;
            cap_id          = rid;
            tick();
        end
        rready = 1'b0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        logic [13:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [13:0] burst_addr[4];
        logic [31:0] held;
        int n;

        vecs[0] = '{1'b1, 4'h1, 32'h0000_0020, 32'h1122_3344, 4'hF, 14'h0008, 32'h0};
        vecs[1] = '{1'b0, 4'h2, 32'h0000_0020, 32'h0,         4'h0, 14'h0008, 32'h1122_3344};
        vecs[2] = '{1'b1, 4'h5, 32'h0000_0021, 32'hAABB_CCDD, 4'h5, 14'h0008, 32'h0};
        vecs[3] = '{1'b0, 4'h6, 32'h0000_0022, 32'h0,         4'h0, 14'h0008, 32'h11BB_33DD};
        vecs[4] = '{1'b0, 4'h3, 32'h0000_0010, 32'h0,         4'h0, 14'h0004, 32'hC0DE_0004};
        vecs[5] = '{1'b1, 4'hE, 32'hFFFF_0030, 32'hDEAD_BEEF, 4'hF, 14'h000C, 32'h0};
        vecs[6] = '{1'b0, 4'hF, 32'h0000_0030, 32'h0,         4'h0, 14'h000C, 32'hDEAD_BEEF};
        vecs[7] = '{1'b1, 4'h4, 32'h0000_0040, 32'h1234_5678, 4'h0, 14'h0010, 32'h0};

        reset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arvalid = 0; rready = 0;
        awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
        wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0;
        tick(); tick();
        reset = 1'b0;
        #1;

        // reset state
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_ram_en",  32'(ram_en),  32'd0);
        chk("rst_rdata",   rdata,        32'h0);
        chk("rst_ids",     32'({rid, bid, bresp}), 32'h0);

        // single-beat table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].id, vecs[i].addr, 4'd0, vecs[i].wd, vecs[i].strb, 0);
                chk($sformatf("v%0d_strobes", i), 32'(cap_n), 32'd1);
                chk($sformatf("v%0d_ram_addr", i), 32'(cap_addr[0]), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_ram_we", i), 32'(cap_we[0]), 32'(vecs[i].strb));
                chk($sformatf("v%0d_bid", i), 32'(cap_id), 32'(vecs[i].id));
                chk($sformatf("v%0d_bresp", i), 32'(cap_bresp), 32'd0);
            end else begin
                do_read(vecs[i].id, vecs[i].addr, 4'd0);
                chk($sformatf("v%0d_strobes", i), 32'(cap_n), 32'd1);
                chk($sformatf("v%0d_ram_addr", i), 32'(cap_addr[0]), 32'(vecs[i].exp_addr));
                chk($sformatf("v%0d_ram_we", i), 32'(cap_we[0]), 32'd0);
                chk($sformatf("v%0d_rdata", i), cap_rdata[0], vecs[i].exp_rdata);
                chk($sformatf("v%0d_rid", i), 32'(cap_id), 32'(vecs[i].id));
                chk($sformatf("v%0d_rlast", i), 32'(cap_rlast[0]), 32'd1);
                chk($sformatf("v%0d_latency", i), 32'(cap_lat[0]), 32'd3);
            end
        end
        // zero-strobe write left the word untouched
        do_read(4'h1, 32'h0000_0040, 4'd0);
        chk("strb0_rdata", cap_rdata[0], 32'hC0DE_0010);

        // burst write wrapping at the top of the RAM window
        burst_addr[0] = 14'h3FFF; burst_addr[1] = 14'h0000;
        burst_addr[2] = 14'h0001; burst_addr[3] = 14'h0002;
        do_write(4'h8, 32'h0000_FFFC, 4'd3, 32'h5000_0000, 4'hF, 3);
        chk("bw_strobes", 32'(cap_n), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bw_addr%0d", k), 32'(cap_addr[k]), 32'(burst_addr[k]));
        chk("bw_bresp", 32'(cap_bresp), 32'd0);
        chk("bw_bid", 32'(cap_id), 32'h8);
        do_read(4'h9, 32'h0000_FFFC, 4'd3);
        chk("br_strobes", 32'(cap_n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("br_addr%0d", k), 32'(cap_addr[k]), 32'(burst_addr[k]));
            chk($sformatf("br_rdata%0d", k), cap_rdata[k], 32'h5000_0000 + 32'(k));
            chk($sformatf("br_rlast%0d", k), 32'(cap_rlast[k]), 32'(k == 3));
            chk($sformatf("br_lat%0d", k), 32'(cap_lat[k]), 32'd3);
        end

        // wlast asserted early: all three beats still written, SLVERR
        do_write(4'hB, 32'h0000_0100, 4'd2, 32'h7000_0000, 4'hF, 1);
        chk("early_strobes", 32'(cap_n), 32'd3);
        chk("early_addr2", 32'(cap_addr[2]), 32'h42);
        chk("early_bresp", 32'(cap_bresp), 32'h2);
        do_read(4'hC, 32'h0000_0108, 4'd0);
        chk("early_beat2", cap_rdata[0], 32'h7000_0002);

        // wvalid before any AW is stalled
        wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wlast = 1'b1;
        #1;
        chk("stall_wready", 32'(wready), 32'd0);
        chk("stall_ram_en", 32'(ram_en), 32'd0);
        tick();
        chk("stall_ram_en2", 32'(ram_en), 32'd0);
        wvalid = 1'b0; wlast = 1'b0;

        // simultaneous AR and AW: write first, read after B handshake
        arid = 4'h7; araddr = 32'h20; arlen = 4'd0; arvalid = 1'b1;
        awid = 4'h9; awaddr = 32'h50; awlen = 4'd0; awvalid = 1'b1;
        #1;
        chk("sim_awready", 32'(awready), 32'd1);
        chk("sim_arready", 32'(arready), 32'd0);
        tick();
        awvalid = 1'b0;
        chk("sim_arready_wr", 32'(arready), 32'd0);
        wdata = 32'h0BAD_F00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        #1;
        chk("sim_ram_addr", 32'(ram_addr), 32'h14);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        chk("sim_bvalid", 32'(bvalid), 32'd1);
        chk("sim_bid", 32'(bid), 32'h9);
        chk("sim_arready_b", 32'(arready), 32'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("sim_arready_idle", 32'(arready), 32'd1);
        do_read(4'h7, 32'h20, 4'd0);
        chk("sim_rdata", cap_rdata[0], 32'h11BB_33DD);
        chk("sim_rid", 32'(cap_id), 32'h7);

        // rready held low, then reset in RD_BEAT
        arid = 4'hA; araddr = 32'h200; arlen = 4'd0; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk("hold_rvalid", 32'(rvalid), 32'd1);
        held = rdata;
        chk("hold_rdata0", held, 32'hC0DE_0080);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("hold_rdata_c%0d", c), rdata, 32'hC0DE_0080);
            chk($sformatf("hold_ram_en_c%0d", c), 32'(ram_en), 32'd0);
            chk($sformatf("hold_rvalid_c%0d", c), 32'(rvalid), 32'd1);
        end
        chk("hold_rid", 32'(rid), 32'hA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_arready", 32'(arready), 32'd1);
        chk("mid_rst_rdata", rdata, 32'h0);
        chk("mid_rst_rid", 32'(rid), 32'h0);
        tick();
        chk("post_rst_idle", 32'({rvalid, ram_en, arready}), 32'b001);
        do_read(4'h2, 32'h10, 4'd0);
        chk("post_rst_rdata", cap_rdata[0], 32'hC0DE_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the RAM word-address width.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port arid  input  4  read transaction ID.
REQ-005 SHALL have port araddr  input  32  read byte address.
REQ-006 SHALL have port arlen  input  4  read beats minus 1.
REQ-007 SHALL have port arvalid  input  1  read address valid.
REQ-008 SHALL have port arready  output  1  read address accepted.
REQ-009 SHALL have port rid  output  4  read response ID.
REQ-010 SHALL have port rdata  output  32  read beat data.
REQ-011 SHALL have port rresp  output  2  read response, always 2'b00.
REQ-012 SHALL have port rlast  output  1  final read beat.
REQ-013 SHALL have port rvalid  output  1  read beat valid.
REQ-014 SHALL have port rready  input  1  master accepts read beat.
REQ-015 SHALL have port awid  input  4  write transaction ID.
REQ-016 SHALL have port awaddr  input  32  write byte address.
REQ-017 SHALL have port awlen  input  4  write beats minus 1.
REQ-018 SHALL have port awvalid  input  1  write address valid.
REQ-019 SHALL have port awready  output  1  write address accepted.
REQ-020 SHALL have port wdata  input  32  write beat data.
REQ-021 SHALL have port wstrb  input  4  byte-lane enables.
REQ-022 SHALL have port wlast  input  1  master-flagged final write beat.
REQ-023 SHALL have port wvalid  input  1  write beat valid.
REQ-024 SHALL have port wready  output  1  write beat accepted.
REQ-025 SHALL have port bid  output  4  write response ID.
REQ-026 SHALL have port bresp  output  2  write response, 2'b00 OKAY or 2'b10 SLVERR.
REQ-027 SHALL have port bvalid  output  1  write response valid.
REQ-028 SHALL have port bready  input  1  master accepts write response.
REQ-029 SHALL have port ram_en  output  1  RAM access strobe.
REQ-030 SHALL have port ram_we  output  4  RAM byte write enables; 0 = read.
REQ-031 SHALL have port ram_addr  output  ADDR_W  RAM word address.
REQ-032 SHALL have port ram_wdata  output  32  RAM write data.
REQ-033 SHALL have port ram_rdata  input  32  RAM read data, valid the cycle after a read strobe.

Function
REQ-034 SHALL use FSM states IDLE, RD_REQ, RD_WAIT, RD_BEAT, WR_BEAT, WR_RESP; one transaction in flight at a time; size fixed at 4 bytes, burst fixed INCR, so arsize/awsize/arburst/awburst/wid are not ported.
REQ-035 SHALL drive awready=1 in IDLE and arready=(IDLE && !awvalid), so a simultaneous AR and AW grants the write first; both are 0 in all other states.
REQ-036 SHALL, on AR/AW handshake, latch ID, word address = addr[ADDR_W+1:2] (addr[1:0] ignored), len, clear beat counter and bresp error flag, then go to RD_REQ or WR_BEAT respectively.
REQ-037 SHALL, in RD_REQ, drive ram_en=1, ram_we=0, ram_addr=current address for exactly one cycle, then go to RD_WAIT.
REQ-038 SHALL, in RD_WAIT, register ram_rdata into rdata and set rvalid, then go to RD_BEAT; first rvalid is visible 3 cycles after the AR handshake cycle.
REQ-039 SHALL hold rdata/rid/rlast stable with rvalid=1 in RD_BEAT until rready; rlast=(counter==len).
REQ-040 SHALL, on an R handshake, return to IDLE if rlast, otherwise increment address and counter and go to RD_REQ.
REQ-041 SHALL drive wready=1 only in WR_BEAT; wvalid before the AW handshake is stalled.
REQ-042 SHALL, on a W handshake, drive ram_en=1, ram_we=wstrb, ram_addr, ram_wdata=wdata combinationally in the same cycle, increment address and counter.
REQ-043 SHALL set the error flag if wlast!=(counter==len) on any beat, and go to WR_RESP after beat len+1 regardless of wlast.
REQ-044 SHALL, in WR_RESP, assert bvalid with bid and bresp (2'b10 if error flag else 2'b00) until bready, then go to IDLE.
REQ-045 SHALL wrap the word address modulo 2^ADDR_W; araddr/awaddr bits above ADDR_W+1 are ignored.
REQ-046 SHALL keep ram_en=0 in all states and cycles not named in REQ-037/REQ-042.

Reset
REQ-047 SHALL, on reset (including mid-transaction), enter IDLE next edge, drop the in-flight transaction, and drive rvalid, bvalid, wready, ram_en, ram_we, rdata, rid, bid, bresp, counter, address to 0.

Verification
REQ-048 Single read: AR addr 0x10, len 0, id 3 at cycle T -> ram_en/ram_addr=4 at T+1, rvalid/rlast=1, rid=3, rdata=RAM word at T+3.
REQ-049 Burst write: AW addr 0xFFFC, len 3, ADDR_W=14, wstrb 4'hF -> ram_addr 0x3FFF, 0, 1, 2 (wrap), bresp 00.
REQ-050 wlast early on beat 1 of len 2 -> 3 beats written, bresp=2'b10.
REQ-051 arvalid and awvalid same cycle -> awready=1, arready=0; read accepted after the B handshake.
REQ-052 rready held low 5 cycles -> rdata stable, no ram_en; reset asserted in RD_BEAT -> rvalid=0 next cycle, FSM in IDLE.
